// File: rtl/map_ss_seq_if.sv
// Bus bundle between the save-state sequencer, the menu controller, the mapper
// ss port and the state buffer.
interface map_ss_seq_if;
    logic       req_save;
    logic       req_load;
    logic       busy;
    logic       done;
    logic       err;
    logic       ss_act;
    logic [7:0] ss_addr;
    logic       ss_we;
    logic [7:0] ss_wdat;
    logic [7:0] ss_rdat;
    logic [7:0] buf_addr;
    logic       buf_we;
    logic [7:0] buf_wdat;
    logic [7:0] buf_rdat;

    modport master (
        input  req_save, req_load, ss_rdat, buf_rdat,
        output busy, done, err, ss_act, ss_addr, ss_we, ss_wdat,
               buf_addr, buf_we, buf_wdat
    );

    modport slave (
        output req_save, req_load, ss_rdat, buf_rdat,
        input  busy, done, err, ss_act, ss_addr, ss_we, ss_wdat,
               buf_addr, buf_we, buf_wdat
    );
endinterface

// File: rtl/map_ss_seq.sv
// Save-state sequencer: copies mapper state registers into a buffer (save) and
// replays them into the mapper (load), pacing each write to a synchronised M2 fall.
module map_ss_seq #(
    parameter int SS_LEN    = 128,
    parameter int SKIP_ADDR = 127,
    parameter int M2_TMO    = 4095
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         m2,
    map_ss_seq_if.master bus
);
    // state  | meaning
    // IDLE   | waiting for a request
    // S_SET  | ss_addr driven, mapper read data settling
    // S_CAP  | ss_rdat written into the buffer
    // L_RD   | buffer and mapper addressed for the next entry
    // L_LAT  | buffer data valid, latched into ss_wdat
    // L_WAIT | ss_we high, waiting for an M2 fall (timeout guarded)
    // L_HOLD | ss_we kept one more clk past the detected fall
    // L_NEXT | advance to the next entry or finish
    // FIN    | one cycle: done pulse unless the load timed out
    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] S_SET  = 4'd1;
    localparam logic [3:0] S_CAP  = 4'd2;
    localparam logic [3:0] L_RD   = 4'd3;
    localparam logic [3:0] L_LAT  = 4'd4;
    localparam logic [3:0] L_WAIT = 4'd5;
    localparam logic [3:0] L_HOLD = 4'd6;
    localparam logic [3:0] L_NEXT = 4'd7;
    localparam logic [3:0] FIN    = 4'd8;

    logic [3:0]  r_state;
    logic [8:0]  r_idx;
    logic [7:0]  r_addr;
    logic [7:0]  r_wdat;
    logic [11:0] r_tmo;
    logic [1:0]  r_arm;
    logic        r_err;
    logic        r_m2_s1;
    logic        r_m2_s2;
    logic        r_m2_d;

    logic w_fall;
    logic w_last;
    logic w_skip;

    assign w_fall = r_m2_d & ~r_m2_s2;
    assign w_last = (r_idx == 9'(SS_LEN - 1));
    assign w_skip = (r_idx == 9'(SKIP_ADDR));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_addr  <= '0;
            r_wdat  <= '0;
            r_tmo   <= '0;
            r_arm   <= '0;
            r_err   <= 1'b0;
            r_m2_s1 <= 1'b0;
            r_m2_s2 <= 1'b0;
            r_m2_d  <= 1'b0;
        end else begin
            r_m2_s1 <= m2;
            r_m2_s2 <= r_m2_s1;
            r_m2_d  <= r_m2_s2;
            case (r_state)
                IDLE: begin
                    if (bus.req_save || bus.req_load) begin
                        r_state <= bus.req_save ? S_SET : L_RD;
                        r_err   <= 1'b0;
                        r_idx   <= '0;
                        r_addr  <= '0;
                    end
                end
                S_SET: r_state <= S_CAP;
                S_CAP: begin
                    if (w_last) begin
                        r_state <= FIN;
                    end else begin
                        r_idx   <= r_idx + 9'd1;
                        r_addr  <= r_idx[7:0] + 8'd1;
                        r_state <= S_SET;
                    end
                end
                L_RD: r_state <= L_LAT;
                L_LAT: begin
                    r_wdat <= bus.buf_rdat;
                    r_tmo  <= 12'(M2_TMO);
                    r_arm  <= '0;
                    r_state <= w_skip ? L_NEXT : L_WAIT;
                end
                L_WAIT: begin
                    // A fall seen in the first two wait cycles came from an M2 edge that
                    // preceded ss_we, so the mapper did not commit on it.
                    if (w_fall && (r_arm == 2'd2)) begin
                        r_state <= L_HOLD;
                    end else if (r_tmo == 12'd0) begin
                        r_err   <= 1'b1;
                        r_state <= FIN;
                    end else begin
                        r_tmo <= r_tmo - 12'd1;
                        if (r_arm != 2'd2) r_arm <= r_arm + 2'd1;
                    end
                end
                L_HOLD: r_state <= L_NEXT;
                L_NEXT: begin
                    if (w_last) begin
                        r_state <= FIN;
                    end else begin
                        r_idx   <= r_idx + 9'd1;
                        r_addr  <= r_idx[7:0] + 8'd1;
                        r_state <= L_RD;
                    end
                end
                FIN:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (r_state != IDLE) && (r_state != FIN);
    assign bus.ss_act   = bus.busy;
    assign bus.ss_we    = (r_state == L_WAIT) || (r_state == L_HOLD);
    assign bus.done     = (r_state == FIN) && !r_err;
    assign bus.err      = r_err;
    assign bus.ss_addr  = r_addr;
    assign bus.ss_wdat  = r_wdat;
    assign bus.buf_addr = r_addr;
    assign bus.buf_we   = (r_state == S_CAP);
    assign bus.buf_wdat = bus.buf_we ? bus.ss_rdat : 8'd0;
endmodule

// File: tb/tb_map_ss_seq.sv
// Directed bench for map_ss_seq with a mapper model committing on negedge m2
// and a registered-read state buffer model.
module tb_map_ss_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic m2    = 1'b0;

    map_ss_seq_if bus();

    map_ss_seq #(.SS_LEN(128), .SKIP_ADDR(127), .M2_TMO(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m2    (m2),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // m2: 0 = held low, 1 = 12-clk period, 2 = random half-periods off the sample points
    int m2_mode = 0;
    initial forever begin
        case (m2_mode)
            1: begin #60; m2 = ~m2; end
            2: begin
                #($urandom_range(25, 40));
                while ((($time % 10) == 64'd5) || (($time % 10) == 64'd8)) #1;
                m2 = ~m2;
            end
            default: begin #10; m2 = 1'b0; end
        endcase
    end

    // mapper: state registers commit on negedge m2, read data combinational
    logic [7:0] map_mem [256];
    logic       map_init = 1'b0;
    int         fall_in_we = 0;
    always @(negedge m2 or posedge map_init) begin
        if (map_init) begin
            for (int i = 0; i < 256; i++) map_mem[i] = 8'(i) ^ 8'h5A;
        end else if (bus.ss_act && bus.ss_we) begin
            map_mem[bus.ss_addr] = bus.ss_wdat;
            fall_in_we++;
        end
    end
    assign bus.ss_rdat = map_mem[bus.ss_addr];

    // state buffer: read data valid one clk after the address
    logic [7:0] buf_mem [256];
    logic       buf_fill = 1'b0;
    always @(posedge clk) begin
        if (buf_fill) begin
            for (int i = 0; i < 256; i++) buf_mem[i] <= 8'(i * 7 + 3);
        end else if (bus.buf_we) begin
            buf_mem[bus.buf_addr] <= bus.buf_wdat;
        end
        bus.buf_rdat <= buf_mem[bus.buf_addr];
    end

    int we_pulses = 0, we_skip = 0, spanned = 0, stab_viol = 0;
    int buf_writes = 0, done_cnt = 0, both_cnt = 0, fall_snap = 0;
    logic [7:0] rise_addr = 8'hFF;
    logic       prev_we = 1'b0;
    logic [7:0] prev_addr = 8'd0, prev_wdat = 8'd0;
    always @(posedge clk) begin
        #3;
        if (bus.buf_we) buf_writes++;
        if (bus.done) done_cnt++;
        if (bus.done && bus.err) both_cnt++;
        if (bus.ss_we && !prev_we) begin
            we_pulses++;
            rise_addr = bus.ss_addr;
            if (bus.ss_addr == 8'd127) we_skip++;
        end
        if (bus.ss_we && prev_we && ((bus.ss_addr != prev_addr) || (bus.ss_wdat != prev_wdat)))
            stab_viol++;
        if (!bus.ss_we && prev_we && (fall_in_we != fall_snap)) spanned++;
        if (!bus.ss_we) fall_snap = fall_in_we;
        prev_we   = bus.ss_we;
        prev_addr = bus.ss_addr;
        prev_wdat = bus.ss_wdat;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic s, input logic l);
        bus.req_save = s;
        bus.req_load = l;
        step();
        bus.req_save = 1'b0;
        bus.req_load = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n, output logic seen);
        n = 0;
        seen = 1'b0;
        while (!seen && (n < budget)) begin
            step();
            n++;
            if (bus.done) seen = 1'b1;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, w0, sk0, sp0, b0, d0, sv0, mism, loads;
        logic seen, found;
        bus.req_save = 1'b0;
        bus.req_load = 1'b0;
        map_init = 1'b1;
        #1 map_init = 1'b0;

        // reset state
        step(); step();
        chk("rst_busy",   32'(bus.busy),     32'd0);
        chk("rst_ss_act", 32'(bus.ss_act),   32'd0);
        chk("rst_ss_we",  32'(bus.ss_we),    32'd0);
        chk("rst_done",   32'(bus.done),     32'd0);
        chk("rst_err",    32'(bus.err),      32'd0);
        chk("rst_buf_we", 32'(bus.buf_we),   32'd0);
        chk("rst_addr",   32'(bus.ss_addr),  32'd0);
        chk("rst_wdat",   32'(bus.ss_wdat),  32'd0);
        rst_n = 1'b1;
        step();

        // save: 2 clk per entry, FIN after the 256th clk past the accepting edge
        m2_mode = 1;
        b0 = buf_writes; w0 = we_pulses;
        pulse_req(1'b1, 1'b0);
        chk("save_busy", 32'(bus.busy), 32'd1);
        wait_done(400, n, seen);
        chk("save_done", 32'(seen), 32'd1);
        chk("save_clks", 32'(n), 32'd256);
        step(); step();
        chk("save_bufw",  32'(buf_writes - b0), 32'd128);
        chk("save_buf0",  32'(buf_mem[0]),   32'h5A);
        chk("save_buf64", 32'(buf_mem[64]),  32'h1A);
        chk("save_buf127",32'(buf_mem[127]), 32'h25);
        chk("save_no_we", 32'(we_pulses - w0), 32'd0);

        // load: buf[a] = a*7+3, skip slot 127 keeps its saved value
        buf_fill = 1'b1; step(); buf_fill = 1'b0; step();
        w0 = we_pulses; sk0 = we_skip; sp0 = spanned;
        pulse_req(1'b0, 1'b1);
        wait_done(4000, n, seen);
        chk("load_done", 32'(seen), 32'd1);
        step(); step();
        chk("load_pulses",  32'(we_pulses - w0), 32'd127);
        chk("load_skip",    32'(we_skip - sk0),  32'd0);
        chk("load_spanned", 32'(spanned - sp0),  32'd127);
        chk("load_chr",     32'(map_mem[0][1:0]), 32'd3);
        chk("load_m1",      32'(map_mem[1]),   32'h0A);
        chk("load_m126",    32'(map_mem[126]), 32'h75);
        chk("load_m127",    32'(map_mem[127]), 32'h25);
        mism = 0;
        for (int a = 0; a < 127; a++) if (map_mem[a] != 8'(a * 7 + 3)) mism++;
        chk("load_all", 32'(mism), 32'd0);

        // simultaneous requests: save wins
        b0 = buf_writes; w0 = we_pulses;
        pulse_req(1'b1, 1'b1);
        step();
        chk("prio_bufwe", 32'(bus.buf_we), 32'd1);
        wait_done(400, n, seen);
        chk("prio_done", 32'(seen), 32'd1);
        step(); step();
        chk("prio_bufw", 32'(buf_writes - b0), 32'd128);
        chk("prio_no_we", 32'(we_pulses - w0), 32'd0);

        // timeout: m2 low, 16 wait clks then err
        m2_mode = 0;
        repeat (12) step();
        d0 = done_cnt;
        pulse_req(1'b0, 1'b1);
        repeat (17) step();
        chk("tmo_we_16",  32'(bus.ss_we), 32'd1);
        chk("tmo_err_16", 32'(bus.err),   32'd0);
        step();
        chk("tmo_err",   32'(bus.err),   32'd1);
        chk("tmo_we",    32'(bus.ss_we), 32'd0);
        chk("tmo_done",  32'(bus.done),  32'd0);
        chk("tmo_busy",  32'(bus.busy),  32'd0);
        step(); step();
        chk("tmo_sticky", 32'(bus.err), 32'd1);
        chk("tmo_no_done", 32'(done_cnt - d0), 32'd0);
        pulse_req(1'b1, 1'b0);
        chk("tmo_err_clr", 32'(bus.err), 32'd0);
        wait_done(400, n, seen);
        chk("tmo_save_done", 32'(seen), 32'd1);

        // reset during L_WAIT, then a fresh load
        m2_mode = 1;
        repeat (3) step();
        pulse_req(1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; (i < 500) && !found; i++) begin
            step();
            if (bus.ss_we && (bus.ss_addr == 8'd5)) found = 1'b1;
        end
        chk("rstm_reach", 32'(found), 32'd1);
        rst_n = 1'b0;
        step();
        chk("rstm_act",  32'(bus.ss_act), 32'd0);
        chk("rstm_we",   32'(bus.ss_we),  32'd0);
        chk("rstm_busy", 32'(bus.busy),   32'd0);
        rst_n = 1'b1;
        step(); step();
        w0 = we_pulses; sp0 = spanned;
        pulse_req(1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; (i < 100) && !found; i++) begin
            step();
            if (we_pulses != w0) found = 1'b1;
        end
        chk("rstm_first_addr", 32'(rise_addr), 32'd0);
        wait_done(4000, n, seen);
        chk("rstm_done", 32'(seen), 32'd1);
        step(); step();
        chk("rstm_pulses",  32'(we_pulses - w0), 32'd127);
        chk("rstm_spanned", 32'(spanned - sp0),  32'd127);

        // asynchronous m2, at least 1000 replayed writes
        m2_mode = 2;
        w0 = we_pulses; sp0 = spanned; sv0 = stab_viol; d0 = done_cnt;
        loads = 0;
        while (((we_pulses - w0) < 1000) && (loads < 12)) begin
            pulse_req(1'b0, 1'b1);
            wait_done(4000, n, seen);
            chk("async_done", 32'(seen), 32'd1);
            loads++;
            step(); step();
        end
        chk("async_pulses",  32'(we_pulses - w0), 32'(loads * 127));
        chk("async_spanned", 32'(spanned - sp0),  32'(we_pulses - w0));
        chk("async_stable",  32'(stab_viol - sv0), 32'd0);
        chk("async_dones",   32'(done_cnt - d0),   32'(loads));
        chk("async_err",     32'(bus.err),         32'd0);
        chk("done_err_excl", 32'(both_cnt),        32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
